// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared types and constants for the L1 data cache controller.
//   l1_state_t    : controller FSM state encoding
//   LINES_DEFAULT : default number of one-word lines
//   idx_width()   : index field width for a given line count
//   tag_width()   : tag field width for a given line count (word address is 30 bits)
package l1_cache_pkg;

   localparam int unsigned LINES_DEFAULT = 16;

   typedef enum logic [1:0] {IDLE, FILL, WTHRU, RESP} l1_state_t;

   function automatic int unsigned idx_width(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned tag_width(input int unsigned lines);
      return 30 - $clog2(lines);
   endfunction

endpackage

// File: rtl/l1_tag_ram.sv
// l1_tag_ram: valid/tag/data array for a direct-mapped, one-word-per-line cache.
// Combinational read port, single synchronous write port. Only valid bits are reset.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset, clears all valid bits
//   rd_idx   in  : read index
//   rd_valid out : valid bit of line rd_idx
//   rd_tag   out : stored tag of line rd_idx
//   rd_data  out : stored data of line rd_idx
//   wr_en    in  : write strobe (sets valid, writes tag and data)
//   wr_idx   in  : write index
//   wr_tag   in  : tag to store
//   wr_data  in  : data to store
module l1_tag_ram
   import l1_cache_pkg::*;
#(
   parameter int unsigned LINES = LINES_DEFAULT,
   parameter int unsigned IDX_W = idx_width(LINES),
   parameter int unsigned TAG_W = tag_width(LINES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [31:0]      data [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Responds to the CPU load/store port (req/ready) and issues word transactions to L2 (req/ack).
// Optional feature macro: L1_CACHE_STATS_EN adds hit_cnt/miss_cnt read counters.
//   clk        in  : clock
//   ci_rst     in  : synchronous active-high reset (invalidates the whole cache)
//   cpu_req    in  : CPU request valid, held stable until cpu_ready
//   cpu_we     in  : 1 = store, 0 = load
//   cpu_addr   in  : byte address, bits [1:0] ignored
//   cpu_wdata  in  : store data
//   cpu_rdata  out : load data, valid with cpu_ready (0 for stores)
//   cpu_ready  out : one-cycle completion pulse
//   mem_req    out : L2 request, held until mem_ack
//   mem_we     out : L2 write enable
//   mem_addr   out : word-aligned L2 address
//   mem_wdata  out : L2 write data
//   mem_ack    in  : L2 completion
//   mem_rdata  in  : L2 read data, valid with mem_ack
//   hit_cnt    out : read hits accepted (L1_CACHE_STATS_EN only)
//   miss_cnt   out : read misses accepted (L1_CACHE_STATS_EN only)
module l1_cache_ctrl
   import l1_cache_pkg::*;
#(
   parameter int unsigned LINES = LINES_DEFAULT
) (
   input  logic        clk,
   input  logic        ci_rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef L1_CACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int unsigned IDX_W = idx_width(LINES);
   localparam int unsigned TAG_W = tag_width(LINES);

   l1_state_t        state;
   logic [IDX_W-1:0] cur_idx;
   logic [TAG_W-1:0] cur_tag;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;
   logic             wr_en;
   logic [31:0]      wr_data;
   logic [1:0]       unused_byte_bits;

   assign unused_byte_bits = cpu_addr[1:0];

   // In IDLE look up the incoming request; while busy use the latched address so the
   // line update does not depend on the CPU keeping its request stable.
   always_comb begin
      if (state == IDLE) begin
         cur_idx = cpu_addr[IDX_W+1:2];
         cur_tag = cpu_addr[31:IDX_W+2];
      end else begin
         cur_idx = mem_addr[IDX_W+1:2];
         cur_tag = mem_addr[31:IDX_W+2];
      end
   end

   assign hit = rd_valid && (rd_tag == cur_tag);

   // Fills always allocate; stores only refresh a line that already holds the address.
   assign wr_en   = !ci_rst && mem_ack && ((state == FILL) || ((state == WTHRU) && hit));
   assign wr_data = (state == FILL) ? mem_rdata : mem_wdata;

   l1_tag_ram #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_tag_ram (
      .clk      (clk),
      .rst      (ci_rst),
      .rd_idx   (cur_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (cur_idx),
      .wr_tag   (cur_tag),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk) begin
      if (ci_rst) begin
         state     <= IDLE;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef L1_CACHE_STATS_EN
         hit_cnt   <= '0;
         miss_cnt  <= '0;
`endif
      end else begin
         cpu_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (cpu_we) begin
                     state     <= WTHRU;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= {cpu_addr[31:2], 2'b00};
                     mem_wdata <= cpu_wdata;
                  end else if (hit) begin
                     state     <= RESP;
                     cpu_ready <= 1'b1;
                     cpu_rdata <= rd_data;
`ifdef L1_CACHE_STATS_EN
                     hit_cnt   <= hit_cnt + 32'd1;
`endif
                  end else begin
                     state     <= FILL;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= {cpu_addr[31:2], 2'b00};
`ifdef L1_CACHE_STATS_EN
                     miss_cnt  <= miss_cnt + 32'd1;
`endif
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= mem_rdata;
               end
            end
            WTHRU: begin
               if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= '0;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
